// File: rtl/stall_ctrl.sv
// Pipeline hazard scheduler for SampleCPU: load-use, divider and bus stalls,
// bubble strobes, divider start/done sequencing and a stall-cycle counter.
module stall_ctrl #(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ext_stall_req,
    input  logic        id_re1,
    input  logic        id_re2,
    input  logic [4:0]  id_raddr1,
    input  logic [4:0]  id_raddr2,
    input  logic        ex_is_load,
    input  logic        ex_we,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_is_div,
    input  logic        div_done,
    output logic [5:0]  stall,
    output logic        ex_bubble,
    output logic        mem_bubble,
    output logic        div_go,
    output logic        div_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {IDLE, DIV_WAIT, DRAIN} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lu;
    logic             cnt_last;
    logic             div_stall;

    assign cnt_last = (cnt == CNT_LAST);

    assign lu = ex_is_load && ex_we && (ex_waddr != 5'd0) &&
                ((id_re1 && (id_raddr1 == ex_waddr)) ||
                 (id_re2 && (id_raddr2 == ex_waddr)));

    // The final timeout cycle releases the stall just like a done cycle, so EX
    // moves on instead of re-launching the same divide from IDLE.
    assign div_stall = ((state == IDLE) && ex_is_div) ||
                       ((state == DIV_WAIT) && !div_done && !cnt_last);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        stall      = 6'b000000;
        ex_bubble  = 1'b0;
        mem_bubble = 1'b0;
        div_go     = 1'b0;
        if (resetn) begin
            if (ext_stall_req) begin
                stall = 6'b111111;
            end else if (div_stall) begin
                stall      = 6'b001111;
                mem_bubble = 1'b1;
            end else if (lu) begin
                stall     = 6'b000111;
                ex_bubble = 1'b1;
            end
            div_go = (state == IDLE) && ex_is_div && !ext_stall_req;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            div_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (stall[0])
                stall_cycles <= stall_cycles + 32'd1;
            case (state)
                IDLE: begin
                    if (ex_is_div && !ext_stall_req) begin
                        state <= DIV_WAIT;
                        cnt   <= '0;
                    end
                end
                DIV_WAIT: begin
                    if (div_done) begin
                        state <= ext_stall_req ? DRAIN : IDLE;
                    end else if (cnt_last) begin
                        div_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // The divide in EX has already completed; wait out the bus stall.
                DRAIN: begin
                    if (!ext_stall_req)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: a behavioural model predicts outputs each
// cycle, the expectation is queued and compared against the sampled DUT.
module tb_stall_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ext_stall_req;
    logic        id_re1, id_re2;
    logic [4:0]  id_raddr1, id_raddr2;
    logic        ex_is_load, ex_we;
    logic [4:0]  ex_waddr;
    logic        ex_is_div, div_done;
    logic [5:0]  stall;
    logic        ex_bubble, mem_bubble, div_go, div_timeout;
    logic [31:0] stall_cycles;

    typedef struct packed {
        logic [5:0]  stall;
        logic        eb;
        logic        mb;
        logic        go;
        logic        to;
        logic [31:0] sc;
    } exp_t;

    exp_t sb[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          m_st;   // 0 idle, 1 waiting on divider, 2 draining
    int          m_cnt;
    logic        m_to;
    logic [31:0] m_sc;

    stall_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn), .ext_stall_req(ext_stall_req),
        .id_re1(id_re1), .id_re2(id_re2), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .ex_is_load(ex_is_load), .ex_we(ex_we), .ex_waddr(ex_waddr),
        .ex_is_div(ex_is_div), .div_done(div_done),
        .stall(stall), .ex_bubble(ex_bubble), .mem_bubble(mem_bubble),
        .div_go(div_go), .div_timeout(div_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic lu, ds;
        e = '0;
        if (resetn !== 1'b1) return e;
        lu = ex_is_load && ex_we && ex_waddr != 0 &&
             ((id_re1 && id_raddr1 == ex_waddr) || (id_re2 && id_raddr2 == ex_waddr));
        ds = (m_st == 0 && ex_is_div) || (m_st == 1 && !div_done && m_cnt != TO - 1);
        if (ext_stall_req)  e.stall = 6'h3f;
        else if (ds)        begin e.stall = 6'h0f; e.mb = 1'b1; end
        else if (lu)        begin e.stall = 6'h07; e.eb = 1'b1; end
        e.go = (m_st == 0) && ex_is_div && !ext_stall_req;
        e.to = m_to;
        e.sc = m_sc;
        return e;
    endfunction

    task automatic model_update(input exp_t e);
        if (resetn !== 1'b1) return;
        if (e.stall[0]) m_sc++;
        case (m_st)
            0: if (ex_is_div && !ext_stall_req) begin m_st = 1; m_cnt = 0; end
            1: if (div_done)              m_st = ext_stall_req ? 2 : 0;
               else if (m_cnt == TO - 1) begin m_to = 1'b1; m_st = 0; end
               else                      m_cnt++;
            default: if (!ext_stall_req) m_st = 0;
        endcase
    endtask

    // Called at a falling edge; applies one cycle of stimulus and returns at the next one.
    task automatic drive(input logic rn, input logic ext,
                         input logic re1, input logic [4:0] ra1,
                         input logic re2, input logic [4:0] ra2,
                         input logic ld, input logic we, input logic [4:0] wa,
                         input logic dv, input logic dn);
        exp_t e, got;
        resetn = rn; ext_stall_req = ext;
        id_re1 = re1; id_raddr1 = ra1; id_re2 = re2; id_raddr2 = ra2;
        ex_is_load = ld; ex_we = we; ex_waddr = wa;
        ex_is_div = dv; div_done = dn;
        if (!rn) begin m_st = 0; m_cnt = 0; m_to = 1'b0; m_sc = '0; end
        e = model_out();
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        check("stall",        64'(stall),        64'(got.stall));
        check("ex_bubble",    64'(ex_bubble),    64'(got.eb));
        check("mem_bubble",   64'(mem_bubble),   64'(got.mb));
        check("div_go",       64'(div_go),       64'(got.go));
        check("div_timeout",  64'(div_timeout),  64'(got.to));
        check("stall_cycles", 64'(stall_cycles), 64'(got.sc));
        @(posedge clk);
        model_update(e);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1, 0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    endtask

    task automatic dv_cyc(input logic ext, input logic dv, input logic dn);
        drive(1, ext, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, dv, dn);
    endtask

    initial begin
        m_st = 0; m_cnt = 0; m_to = 1'b0; m_sc = '0;
        resetn = 1'b0; ext_stall_req = 1'b0;
        id_re1 = 1'b0; id_re2 = 1'b0; id_raddr1 = '0; id_raddr2 = '0;
        ex_is_load = 1'b0; ex_we = 1'b0; ex_waddr = '0;
        ex_is_div = 1'b0; div_done = 1'b0;
        @(negedge clk);

        // Reset forces outputs low even with stall-inducing inputs present.
        drive(0, 1, 1, 5'd5, 0, 5'd0, 1, 1, 5'd5, 1, 0);
        drive(0, 0, 1, 5'd5, 0, 5'd0, 1, 1, 5'd5, 1, 0);
        idle();

        // Load-use on operand 2, then the load has moved to MEM.
        drive(1, 0, 1, 5'd3, 1, 5'd5, 1, 1, 5'd5, 0, 0);
        drive(1, 0, 1, 5'd3, 1, 5'd5, 0, 0, 5'd0, 0, 0);
        check("lu_stall_cycles", 64'(stall_cycles), 64'd1);

        // No hazard: r0, non-matching register, read-enable low, write-enable low.
        drive(1, 0, 1, 5'd0, 0, 5'd0, 1, 1, 5'd0, 0, 0);
        drive(1, 0, 1, 5'd6, 1, 5'd7, 1, 1, 5'd5, 0, 0);
        drive(1, 0, 0, 5'd5, 0, 5'd5, 1, 1, 5'd5, 0, 0);
        drive(1, 0, 1, 5'd5, 0, 5'd0, 1, 0, 5'd5, 0, 0);
        // Bus stall outranks load-use.
        drive(1, 1, 1, 5'd9, 0, 5'd0, 1, 1, 5'd9, 0, 0);

        // Divide with done on the 4th wait cycle.
        dv_cyc(0, 1, 0);
        dv_cyc(0, 1, 0);
        dv_cyc(0, 1, 0);
        dv_cyc(0, 1, 0);
        dv_cyc(0, 1, 1);
        check("div_stall_cycles", 64'(stall_cycles), 64'd6);
        idle();

        // Divide blocked by bus stall in IDLE, then done under bus stall -> DRAIN.
        dv_cyc(1, 1, 0);
        dv_cyc(0, 1, 0);
        dv_cyc(0, 1, 0);
        dv_cyc(1, 1, 1);
        dv_cyc(1, 1, 1);
        dv_cyc(0, 1, 1);
        idle();

        // Timeout: done never comes, bus stall mid-wait keeps the counter running.
        dv_cyc(0, 1, 0);
        for (int i = 0; i < TO; i++) dv_cyc(i == 3, 1, 0);
        idle();
        check("timeout_sticky", 64'(div_timeout), 64'd1);
        idle();

        // Asynchronous reset mid-divide, then a fresh divide start.
        dv_cyc(0, 1, 0);
        dv_cyc(0, 1, 0);
        drive(0, 1, 1, 5'd4, 0, 5'd0, 1, 1, 5'd4, 1, 0);
        check("rst_timeout_clear", 64'(div_timeout), 64'd0);
        dv_cyc(0, 1, 0);
        dv_cyc(0, 1, 1);
        idle();

        // Random traffic over a small register range.
        for (int i = 0; i < 60; i++) begin
            drive(1, $urandom_range(4) == 0,
                  1'($urandom), 5'($urandom_range(3)),
                  1'($urandom), 5'($urandom_range(3)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(3)),
                  $urandom_range(3) == 0, $urandom_range(2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall/bubble scheduler for the 5-stage SampleCPU core. It sits beside the ID-stage register file and forwarding paths and resolves the hazards forwarding cannot cover: load-use, the multi-cycle divider, and external bus stalls. It drives the shared `stall[5:0]` vector, plus bubble-insert strobes for EX and MEM. It also sequences the divider start/done handshake and keeps a stall-cycle counter.

## Interface
- `DIV_TIMEOUT`, 64: maximum DIV_WAIT cycles before abort.
- `CNT_W`, 7: width of the divider wait counter; must hold DIV_TIMEOUT.
- `clk`  in  1  core clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ext_stall_req`  in  1  bus not ready; freeze the whole pipe.
- `id_re1`, `id_re2`  in  1 each  ID reads operand 1/2.
- `id_raddr1`, `id_raddr2`  in  5 each  ID source register numbers.
- `ex_is_load`  in  1  EX holds a load.
- `ex_we`  in  1  EX writes the register file.
- `ex_waddr`  in  5  EX destination register.
- `ex_is_div`  in  1  EX holds div/divu.
- `div_done`  in  1  divider result valid; held until next `div_go`.
- `stall`  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold.
- `ex_bubble`  out  1  load NOP into ID/EX register this cycle.
- `mem_bubble`  out  1  load NOP into EX/MEM register this cycle.
- `div_go`  out  1  one-cycle divider start pulse.
- `div_timeout`  out  1  sticky abort flag.
- `stall_cycles`  out  32  count of cycles with `stall[0]`=1; wraps.

## Operation
- FSM states: IDLE, DIV_WAIT, DRAIN. Reset state is IDLE.
- Load-use hazard (`lu`): `ex_is_load & ex_we & ex_waddr!=0 & ((id_re1 & id_raddr1==ex_waddr) | (id_re2 & id_raddr2==ex_waddr))`.
- Output priority, evaluated combinationally each cycle:
  1. `ext_stall_req`=1: `stall`=6'b111111, both bubbles 0, `div_go`=0.
  2. Divider stall: `stall`=6'b001111, `mem_bubble`=1, `ex_bubble`=0. Active in any of these cases:
     - IDLE with `ex_is_div`.
     - DIV_WAIT with `div_done`=0.
  3. `lu`: `stall`=6'b000111, `ex_bubble`=1.
  4. Otherwise: `stall`=0, both bubbles 0.
- FSM transitions:
  - IDLE with `ex_is_div` and no `ext_stall_req`: `div_go`=1, counter cleared, go to DIV_WAIT.
  - IDLE with `ext_stall_req`: no `div_go`; the divide is retried next cycle.
  - DIV_WAIT with `div_done`=1 and no `ext_stall_req`: divider stall drops that cycle so EX captures the result; go to IDLE.
  - DIV_WAIT with `div_done`=1 and `ext_stall_req`: go to DRAIN.
  - DIV_WAIT with `div_done`=0: counter +1. When the counter reaches DIV_TIMEOUT-1, set `div_timeout`, go to IDLE and release the stall (the aborted divide leaves EX with an undefined result).
  - DIV_WAIT with `ext_stall_req` and `div_done`=0: the counter keeps counting.
  - DRAIN: no divider stall and no `div_go`, even if `ex_is_div`=1 (it is the same divide). Go to IDLE on the first cycle with `ext_stall_req`=0; that cycle is unstalled.
- `div_timeout` clears only on reset.
- `stall_cycles` increments on every cycle with `stall[0]`=1 and wraps from 0xFFFFFFFF to 0.
- Register 0 never creates a load-use hazard.

## Timing
- All hazard outputs are combinational from current state and inputs, with zero-cycle latency.
- While `resetn`=0, all outputs are forced to 0 regardless of inputs.
- Reset values: state IDLE, counter 0, `div_timeout` 0, `stall_cycles` 0.
- Asynchronous reset mid-divide returns to IDLE immediately. The divider is not told; its next `div_go` restarts it.
- A load-use stall lasts exactly 1 cycle: after the bubble the load is in MEM and `lu` drops.
- A divide occupies 1 + N cycles in EX, where N is the number of DIV_WAIT cycles up to and including the `div_done` cycle.
- `div_go` is high only in IDLE, for exactly one cycle per divide.

## Test plan
- Load-use: EX load to r5 with ID reading r5 on operand 2 -> one cycle of `stall`=000111 with `ex_bubble`=1, then 000000; `stall_cycles`=1.
- r0 and non-matching cases: EX load to r0 with ID reading r0 -> `stall`=0. EX load to r5 with ID reading r6 -> `stall`=0.
- Divide: `ex_is_div` pulse, `div_done` on the 4th DIV_WAIT cycle:
  - `div_go` is high for 1 cycle.
  - `stall`=001111 and `mem_bubble`=1 for 4 cycles (IDLE plus 3 DIV_WAIT).
  - `stall`=0 on the done cycle; state returns to IDLE.
- Done under bus stall: `div_done` and `ext_stall_req` both high for 2 cycles -> state DRAIN with `stall`=111111 and no second `div_go`; the cycle after `ext_stall_req` drops shows `stall`=0 and state IDLE.
- Timeout with DIV_TIMEOUT=8 and `div_done` held 0 -> `div_timeout` rises after 8 DIV_WAIT cycles and stays 1; the stall releases.
- Reset mid-divide: drop `resetn` in DIV_WAIT -> all outputs 0 immediately; after release, `ex_is_div` produces a fresh `div_go`.
